// File: rtl/spi_status_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_status_pkg
//  Description : Shared types and constants for the SPI status transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_status_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   localparam logic [3:0] HDR_NIBBLE  = 4'hA;
   localparam logic [7:0] NO_RESULT   = 8'hFF;
   localparam logic [7:0] FILL_BYTE   = 8'h00;
   localparam int         FRAME_BYTES = 3;

   // byte_idx value while the last real byte is on the wire, and the
   // saturated value meaning "whole frame delivered, now sending filler"
   localparam logic [1:0] LAST_BYTE_IDX = 2'(FRAME_BYTES - 1);
   localparam logic [1:0] DONE_IDX      = 2'(FRAME_BYTES);

   // Byte to load once the byte at position idx has been fully shifted out
   function automatic logic [7:0] next_byte(input logic [1:0] idx,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
      logic [7:0] nb;
      nb = FILL_BYTE;
      case (idx)
         2'd0:    nb = b1;
         2'd1:    nb = b2;
         default: nb = FILL_BYTE;
      endcase
      return nb;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchronizer plus history flop producing the
//                synchronized level and single-cycle rise/fall strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   // Synchronizer chain and one-cycle history; reset to the line's idle level
   // so that leaving reset never looks like an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  level_o & ~hist_q;
   assign fall_o  = ~level_o &  hist_q;

endmodule
`default_nettype wire

// File: rtl/spi_status_tx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_status_tx
//  Description : SPI mode-0 slave MISO transmitter. Snapshots status and
//                classification result on chip-select and shifts out a
//                3-byte frame {A,status} / result / xor, then filler.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_status_tx
   import spi_status_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RESULT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sclk_i,
   input  logic                cs_n_i,
   output logic                miso_o,
   output logic                miso_oe_o,
   input  logic [3:0]          status_code_i,
   input  logic                result_ready_i,
   input  logic [RESULT_W-1:0] result_class_i,
   output logic                frame_active_o,
   output logic                tx_done_o,
   output logic                result_ack_o,
   output logic                frame_abort_o
);

   logic w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic w_cs_level, w_cs_rise, w_cs_fall;
   logic w_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .d_i     (sclk_i),
      .level_o (w_sclk_level),
      .rise_o  (w_sclk_rise),
      .fall_o  (w_sclk_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk     (clk),
      .rst     (rst),
      .d_i     (cs_n_i),
      .level_o (w_cs_level),
      .rise_o  (w_cs_rise),
      .fall_o  (w_cs_fall)
   );

   // Only the strobes we act on are needed; levels and sclk rise are spare
   assign w_unused = ^{w_sclk_level, w_sclk_rise, w_cs_level};

   state_e     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [1:0] byte_idx_q, byte_idx_d;
   logic [7:0] b1_q, b1_d;
   logic [7:0] b2_q, b2_d;
   logic       ack_pend_q, ack_pend_d;
   logic       miso_q, miso_d;
   logic       oe_q, oe_d;
   logic       active_q, active_d;
   logic       tx_done_q, tx_done_d;
   logic       ack_q, ack_d;
   logic       abort_q, abort_d;

   logic [7:0] w_b0;
   logic [7:0] w_b1;

   assign w_b0 = {HDR_NIBBLE, status_code_i};
   assign w_b1 = result_ready_i ? 8'(result_class_i) : NO_RESULT;

   // State, snapshot and registered-output flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= 8'h00;
         bit_cnt_q  <= 3'd0;
         byte_idx_q <= 2'd0;
         b1_q       <= 8'h00;
         b2_q       <= 8'h00;
         ack_pend_q <= 1'b0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         active_q   <= 1'b0;
         tx_done_q  <= 1'b0;
         ack_q      <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_idx_q <= byte_idx_d;
         b1_q       <= b1_d;
         b2_q       <= b2_d;
         ack_pend_q <= ack_pend_d;
         miso_q     <= miso_d;
         oe_q       <= oe_d;
         active_q   <= active_d;
         tx_done_q  <= tx_done_d;
         ack_q      <= ack_d;
         abort_q    <= abort_d;
      end
   end

   // Next-state logic; outputs are derived from the next state so they flop
   // in the same cycle the state changes
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_idx_d = byte_idx_q;
      b1_d       = b1_q;
      b2_d       = b2_q;
      ack_pend_d = ack_pend_q;
      tx_done_d  = 1'b0;
      ack_d      = 1'b0;
      abort_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d  = 3'd0;
            byte_idx_d = 2'd0;
            if (w_cs_fall) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (w_cs_rise) begin
               state_d = ST_IDLE;
               abort_d = 1'b1;
            end else begin
               b1_d       = w_b1;
               b2_d       = w_b0 ^ w_b1;
               ack_pend_d = result_ready_i;
               shift_d    = w_b0;
               bit_cnt_d  = 3'd0;
               byte_idx_d = 2'd0;
               state_d    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            // Chip-select release takes priority over a coincident sclk edge
            if (w_cs_rise) begin
               state_d = ST_IDLE;
               abort_d = (byte_idx_q != DONE_IDX);
            end else if (w_sclk_fall) begin
               if (bit_cnt_q == 3'd7) begin
                  shift_d    = next_byte(byte_idx_q, b1_q, b2_q);
                  bit_cnt_d  = 3'd0;
                  byte_idx_d = (byte_idx_q == DONE_IDX) ? DONE_IDX
                                                        : byte_idx_q + 2'd1;
                  if (byte_idx_q == LAST_BYTE_IDX) begin
                     tx_done_d = 1'b1;
                     ack_d     = ack_pend_q;
                  end
               end else begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      miso_d   = (state_d == ST_SHIFT) ? shift_d[7] : 1'b0;
      oe_d     = (state_d == ST_SHIFT);
      active_d = (state_d != ST_IDLE);
   end

   assign miso_o         = miso_q;
   assign miso_oe_o      = oe_q;
   assign frame_active_o = active_q;
   assign tx_done_o      = tx_done_q;
   assign result_ack_o   = ack_q;
   assign frame_abort_o  = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_status_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_status_tx
//  Description : Directed self-checking bench for spi_status_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_status_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       cs_n = 1'b1;
   logic [3:0] status_code = 4'h0;
   logic       result_ready = 1'b0;
   logic [3:0] result_class = 4'h0;
   logic       miso, miso_oe, frame_active, tx_done, result_ack, frame_abort;

   int checks = 0;
   int errors = 0;
   int tx_cnt = 0, ack_cnt = 0, abort_cnt = 0, ack_solo = 0;

   spi_status_tx #(.SYNC_STAGES(2), .RESULT_W(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .sclk_i         (sclk),
      .cs_n_i         (cs_n),
      .miso_o         (miso),
      .miso_oe_o      (miso_oe),
      .status_code_i  (status_code),
      .result_ready_i (result_ready),
      .result_class_i (result_class),
      .frame_active_o (frame_active),
      .tx_done_o      (tx_done),
      .result_ack_o   (result_ack),
      .frame_abort_o  (frame_abort)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (tx_done)                  tx_cnt++;
      if (result_ack)               ack_cnt++;
      if (frame_abort)              abort_cnt++;
      if (result_ack && !tx_done)   ack_solo++;
   end

   // Host side of one frame: sclk period is 8 clk, miso sampled just before
   // each rising sclk edge; chg_at >= 0 changes status_code before that bit
   task automatic run_frame(input int nbits, input int chg_at, input logic [3:0] chg_val,
                            output logic [31:0] data, output logic oe_seen);
      data    = 32'h0;
      oe_seen = 1'b1;
      @(negedge clk) cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) status_code = chg_val;
         data = {data[30:0], miso};
         if (miso_oe !== 1'b1) oe_seen = 1'b0;
         sclk = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
         repeat (4) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (miso !== 1'b0)         begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
      checks++; if (miso_oe !== 1'b0)      begin errors++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
      checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", frame_active); end
      checks++; if ({tx_done, result_ack, frame_abort} !== 3'b000)
         begin errors++; $display("FAIL reset_pulses: got %b want 000", {tx_done, result_ack, frame_abort}); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (miso_oe !== 1'b0)      begin errors++; $display("FAIL post_reset_oe: got %b want 0", miso_oe); end
   endtask

   task automatic test_no_result();
      logic [31:0] d; logic oe; int t0, a0, b0;
      status_code = 4'h1; result_ready = 1'b0;
      t0 = tx_cnt; a0 = ack_cnt; b0 = abort_cnt;
      run_frame(24, -1, 4'h0, d, oe);
      checks++; if (d[23:0] !== 24'hA1FF5E) begin errors++; $display("FAIL noresult_data: got %h want a1ff5e", d[23:0]); end
      checks++; if (tx_cnt - t0 != 1)      begin errors++; $display("FAIL noresult_txdone: got %0d want 1", tx_cnt - t0); end
      checks++; if (ack_cnt - a0 != 0)     begin errors++; $display("FAIL noresult_ack: got %0d want 0", ack_cnt - a0); end
      checks++; if (abort_cnt - b0 != 0)   begin errors++; $display("FAIL noresult_abort: got %0d want 0", abort_cnt - b0); end
      checks++; if (oe !== 1'b1)           begin errors++; $display("FAIL noresult_oe_during: got %b want 1", oe); end
      checks++; if ({miso_oe, frame_active} !== 2'b00)
         begin errors++; $display("FAIL noresult_idle_after: got %b want 00", {miso_oe, frame_active}); end
   endtask

   task automatic test_with_result();
      logic [31:0] d; logic oe; int t0, a0, s0;
      status_code = 4'h8; result_ready = 1'b1; result_class = 4'd7;
      t0 = tx_cnt; a0 = ack_cnt; s0 = ack_solo;
      run_frame(24, -1, 4'h0, d, oe);
      checks++; if (d[23:0] !== 24'hA807AF) begin errors++; $display("FAIL result_data: got %h want a807af", d[23:0]); end
      checks++; if (tx_cnt - t0 != 1)      begin errors++; $display("FAIL result_txdone: got %0d want 1", tx_cnt - t0); end
      checks++; if (ack_cnt - a0 != 1)     begin errors++; $display("FAIL result_ack: got %0d want 1", ack_cnt - a0); end
      checks++; if (ack_solo - s0 != 0)    begin errors++; $display("FAIL result_ack_coincident: got %0d stray want 0", ack_solo - s0); end
      result_ready = 1'b0;
   endtask

   task automatic test_long_frame();
      logic [31:0] d; logic oe; int t0, b0;
      status_code = 4'h4;
      t0 = tx_cnt; b0 = abort_cnt;
      run_frame(32, -1, 4'h0, d, oe);
      checks++; if (d !== 32'hA4FF5B00)  begin errors++; $display("FAIL long_data: got %h want a4ff5b00", d); end
      checks++; if (tx_cnt - t0 != 1)    begin errors++; $display("FAIL long_txdone: got %0d want 1", tx_cnt - t0); end
      checks++; if (abort_cnt - b0 != 0) begin errors++; $display("FAIL long_abort: got %0d want 0", abort_cnt - b0); end
      checks++; if (oe !== 1'b1)         begin errors++; $display("FAIL long_oe_during: got %b want 1", oe); end
   endtask

   task automatic test_abort();
      logic [31:0] d; logic oe; int t0, b0;
      status_code = 4'h3;
      t0 = tx_cnt; b0 = abort_cnt;
      run_frame(12, -1, 4'h0, d, oe);
      checks++; if (d[11:0] !== 12'hA3F)  begin errors++; $display("FAIL abort_partial_data: got %h want a3f", d[11:0]); end
      checks++; if (abort_cnt - b0 != 1)  begin errors++; $display("FAIL abort_pulse: got %0d want 1", abort_cnt - b0); end
      checks++; if (tx_cnt - t0 != 0)     begin errors++; $display("FAIL abort_txdone: got %0d want 0", tx_cnt - t0); end
      checks++; if (miso_oe !== 1'b0)     begin errors++; $display("FAIL abort_oe: got %b want 0", miso_oe); end
      t0 = tx_cnt; b0 = abort_cnt;
      run_frame(24, -1, 4'h0, d, oe);
      checks++; if (d[23:0] !== 24'hA3FF5C) begin errors++; $display("FAIL abort_next_data: got %h want a3ff5c", d[23:0]); end
      checks++; if (tx_cnt - t0 != 1 || abort_cnt - b0 != 0)
         begin errors++; $display("FAIL abort_next_pulses: got tx=%0d abort=%0d want 1/0", tx_cnt - t0, abort_cnt - b0); end
   endtask

   task automatic test_status_change();
      logic [31:0] d; logic oe;
      status_code = 4'h2;
      run_frame(24, 3, 4'h8, d, oe);
      checks++; if (d[23:0] !== 24'hA2FF5D) begin errors++; $display("FAIL frozen_data: got %h want a2ff5d", d[23:0]); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] d; logic oe; int t0, a0, b0;
      status_code = 4'h5; result_ready = 1'b1; result_class = 4'd9;
      t0 = tx_cnt; a0 = ack_cnt; b0 = abort_cnt;
      @(negedge clk) cs_n = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         sclk = 1'b1; repeat (4) @(negedge clk);
         sclk = 1'b0; repeat (4) @(negedge clk);
      end
      checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL midrst_active_before: got %b want 1", frame_active); end
      rst = 1'b1;
      #1;
      checks++; if ({miso_oe, miso, frame_active} !== 3'b000)
         begin errors++; $display("FAIL midrst_outputs: got %b want 000", {miso_oe, miso, frame_active}); end
      cs_n = 1'b1; sclk = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (tx_cnt != t0 || ack_cnt != a0 || abort_cnt != b0)
         begin errors++; $display("FAIL midrst_pulses: got tx=%0d ack=%0d abort=%0d want 0/0/0", tx_cnt - t0, ack_cnt - a0, abort_cnt - b0); end
      run_frame(24, -1, 4'h0, d, oe);
      checks++; if (d[23:0] !== 24'hA509AC) begin errors++; $display("FAIL midrst_next_data: got %h want a509ac", d[23:0]); end
      checks++; if (tx_cnt - t0 != 1 || ack_cnt - a0 != 1)
         begin errors++; $display("FAIL midrst_next_pulses: got tx=%0d ack=%0d want 1/1", tx_cnt - t0, ack_cnt - a0); end
      result_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_no_result();
      test_with_result();
      test_long_frame();
      test_abort();
      test_status_change();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
